// File: rtl/baw_pkg.sv
// Shared encodings for the Black-and-White game controller: FSM states,
// result codes, leader values and button indices/priority.
package baw_pkg;

   typedef enum logic [2:0] {
      INIT    = 3'd0,
      RASP    = 3'd1,
      BAWP    = 3'd2,
      P1_TURN = 3'd3,
      P2_TURN = 3'd4,
      MATCH   = 3'd5,
      GAME    = 3'd6
   } state_e;

   typedef enum logic [1:0] {
      RES_NONE = 2'b00,
      RES_P1   = 2'b01,
      RES_P2   = 2'b10,
      RES_DRAW = 2'b11
   } res_e;

   localparam logic LEADER_P1 = 1'b0;
   localparam logic LEADER_P2 = 1'b1;

   localparam int N_BTN      = 5;
   localparam int BTN_CENTER = 0;
   localparam int BTN_TOP    = 1;
   localparam int BTN_BOTTOM = 2;
   localparam int BTN_LEFT   = 3;
   localparam int BTN_RIGHT  = 4;

   typedef enum logic [2:0] {
      PR_NONE,
      PR_BOTTOM,
      PR_CENTER,
      PR_TOP,
      PR_LEFT,
      PR_RIGHT
   } press_e;

   // Only one press acts per cycle; bottom must win so a reset request is never lost.
   function automatic press_e pick_press(input logic [N_BTN-1:0] p);
      if (p[BTN_BOTTOM]) return PR_BOTTOM;
      if (p[BTN_CENTER]) return PR_CENTER;
      if (p[BTN_TOP])    return PR_TOP;
      if (p[BTN_LEFT])   return PR_LEFT;
      if (p[BTN_RIGHT])  return PR_RIGHT;
      return PR_NONE;
   endfunction

endpackage

// File: rtl/baw_btn_edge.sv
// Rising-edge detector: a press is a level that was low on the previous cycle.
module baw_btn_edge #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] level,
   output logic [W-1:0] press
);

   logic [W-1:0] prev_q, prev_d;

   always_comb prev_d = level;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) prev_q <= '0;
      else       prev_q <= prev_d;
   end

   assign press = level & ~prev_q;

endmodule

// File: rtl/baw_game_ctrl.sv
// Black-and-White game controller: card commits, turn order, round scoring
// and game termination, driven by edge-detected button presses.
module baw_game_ctrl
   import baw_pkg::*;
#(
   parameter int N_CARDS  = 9,
   parameter int N_ROUNDS = 9,
   parameter int CW       = $clog2(N_CARDS),
   parameter int RW       = $clog2(N_ROUNDS + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               btn_center,
   input  logic               btn_top,
   input  logic               btn_bottom,
   input  logic               btn_left,
   input  logic               btn_right,
   input  logic [N_CARDS-1:0] sw,
   output logic [2:0]         state,
   output logic [N_CARDS-1:0] p1_used,
   output logic [N_CARDS-1:0] p2_used,
   output logic [CW-1:0]      p1_card,
   output logic [CW-1:0]      p2_card,
   output logic               p1_locked,
   output logic               p2_locked,
   output logic               p1_black,
   output logic               p2_black,
   output logic               leader,
   output logic [RW-1:0]      round,
   output logic [RW-1:0]      win,
   output logic [RW-1:0]      lose,
   output logic [RW-1:0]      draw,
   output logic [1:0]         match_result,
   output logic [1:0]         game_result,
   output logic               finish,
   output logic               err
);

   localparam logic [RW-1:0]      ROUND_MAX = RW'(N_ROUNDS);
   localparam logic [N_CARDS-1:0] SW_ONE    = N_CARDS'(1);

   function automatic logic is_onehot(input logic [N_CARDS-1:0] v);
      return (v != '0) && ((v & (v - SW_ONE)) == '0);
   endfunction

   function automatic logic [CW-1:0] encode(input logic [N_CARDS-1:0] v);
      logic [CW-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_CARDS; i++)
         if (v[i]) idx = CW'(i);
      return idx;
   endfunction

   function automatic logic [RW-1:0] sat_inc(input logic [RW-1:0] c);
      return (c == ROUND_MAX) ? c : c + RW'(1);
   endfunction

   logic [N_BTN-1:0] btn_lvl, btn_press;
   press_e           pr;

   assign btn_lvl = {btn_right, btn_left, btn_bottom, btn_top, btn_center};

   baw_btn_edge #(.W(N_BTN)) u_btn_edge (
      .clk   (clk),
      .reset (reset),
      .level (btn_lvl),
      .press (btn_press)
   );

   assign pr = pick_press(btn_press);

   // Index 0 is P1, index 1 is P2 throughout.
   state_e                   state_q, state_d;
   logic [1:0][N_CARDS-1:0]  used_q, used_d;
   logic [1:0][CW-1:0]       card_q, card_d;
   logic [1:0]               lock_q, lock_d;
   logic                     leader_q, leader_d;
   logic [RW-1:0]            round_q, round_d;
   logic [RW-1:0]            win_q, win_d;
   logic [RW-1:0]            lose_q, lose_d;
   logic [RW-1:0]            draw_q, draw_d;
   res_e                     mres_q, mres_d;
   res_e                     gres_q, gres_d;
   logic                     err_q, err_d;

   logic pl;
   logic commit_ok;
   logic finish_w;

   assign pl        = (state_q == P2_TURN);
   assign commit_ok = is_onehot(sw) && ((used_q[pl] & sw) == '0) && !lock_q[pl];
   assign finish_w  = (int'(win_q) * 2 > N_ROUNDS) || (int'(lose_q) * 2 > N_ROUNDS) ||
                      (round_q == ROUND_MAX);

   always_comb begin
      state_d  = state_q;
      used_d   = used_q;
      card_d   = card_q;
      lock_d   = lock_q;
      leader_d = leader_q;
      round_d  = round_q;
      win_d    = win_q;
      lose_d   = lose_q;
      draw_d   = draw_q;
      mres_d   = mres_q;
      gres_d   = gres_q;
      err_d    = 1'b0;

      if (pr == PR_BOTTOM) begin
         state_d  = INIT;
         used_d   = '0;
         card_d   = '0;
         lock_d   = '0;
         leader_d = LEADER_P1;
         round_d  = '0;
         win_d    = '0;
         lose_d   = '0;
         draw_d   = '0;
         mres_d   = RES_NONE;
         gres_d   = RES_NONE;
      end else begin
         unique case (state_q)
            INIT: if (pr == PR_CENTER) state_d = RASP;
            RASP: if (pr == PR_TOP)    state_d = BAWP;
            BAWP: begin
               unique case (pr)
                  // The follower may only play once the leader has committed.
                  PR_LEFT: begin
                     if (leader_q == LEADER_P2 && !lock_q[1]) err_d   = 1'b1;
                     else                                     state_d = P1_TURN;
                  end
                  PR_RIGHT: begin
                     if (leader_q == LEADER_P1 && !lock_q[0]) err_d   = 1'b1;
                     else                                     state_d = P2_TURN;
                  end
                  PR_CENTER: begin
                     if (&lock_q) begin
                        state_d = MATCH;
                        round_d = sat_inc(round_q);
                        if (card_q[0] > card_q[1]) begin
                           mres_d   = RES_P1;
                           win_d    = sat_inc(win_q);
                           leader_d = LEADER_P1;
                        end else if (card_q[0] < card_q[1]) begin
                           mres_d   = RES_P2;
                           lose_d   = sat_inc(lose_q);
                           leader_d = LEADER_P2;
                        end else begin
                           mres_d   = RES_DRAW;
                           draw_d   = sat_inc(draw_q);
                        end
                     end else begin
                        err_d = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
            P1_TURN, P2_TURN: begin
               if (pr == PR_CENTER) begin
                  if (commit_ok) begin
                     card_d[pl] = encode(sw);
                     used_d[pl] = used_q[pl] | sw;
                     lock_d[pl] = 1'b1;
                     state_d    = BAWP;
                  end else begin
                     err_d = 1'b1;
                  end
               end else if (pr == PR_TOP) begin
                  state_d = BAWP;
               end
            end
            MATCH: begin
               if (pr == PR_TOP) begin
                  if (finish_w) begin
                     state_d = GAME;
                     if (win_q > lose_q)      gres_d = RES_P1;
                     else if (lose_q > win_q) gres_d = RES_P2;
                     else                     gres_d = RES_DRAW;
                  end else begin
                     state_d = RASP;
                     lock_d  = '0;
                     mres_d  = RES_NONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= INIT;
         used_q   <= '0;
         card_q   <= '0;
         lock_q   <= '0;
         leader_q <= LEADER_P1;
         round_q  <= '0;
         win_q    <= '0;
         lose_q   <= '0;
         draw_q   <= '0;
         mres_q   <= RES_NONE;
         gres_q   <= RES_NONE;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         used_q   <= used_d;
         card_q   <= card_d;
         lock_q   <= lock_d;
         leader_q <= leader_d;
         round_q  <= round_d;
         win_q    <= win_d;
         lose_q   <= lose_d;
         draw_q   <= draw_d;
         mres_q   <= mres_d;
         gres_q   <= gres_d;
         err_q    <= err_d;
      end
   end

   assign state        = state_q;
   assign p1_used      = used_q[0];
   assign p2_used      = used_q[1];
   assign p1_card      = card_q[0];
   assign p2_card      = card_q[1];
   assign p1_locked    = lock_q[0];
   assign p2_locked    = lock_q[1];
   assign p1_black     = card_q[0][0];
   assign p2_black     = card_q[1][0];
   assign leader       = leader_q;
   assign round        = round_q;
   assign win          = win_q;
   assign lose         = lose_q;
   assign draw         = draw_q;
   assign match_result = mres_q;
   assign game_result  = gres_q;
   assign finish       = finish_w;
   assign err          = err_q;

endmodule

// File: tb/tb_baw_game_ctrl.sv
// Bench for baw_game_ctrl: directed scenarios plus random button/switch traffic
// checked against a rule-level game model.
module tb_baw_game_ctrl;

   localparam int NC = 9;
   localparam int NR = 9;
   localparam int C = 0, T = 1, B = 2, L = 3, R = 4;
   localparam int S_INIT = 0, S_RASP = 1, S_BAWP = 2, S_P1 = 3, S_P2 = 4, S_MATCH = 5, S_GAME = 6;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [4:0] lv = '0;
   logic [8:0] sw = '0;
   logic [8:0] cur_sw = '0;
   logic bc, bt, bb, bl, br;
   assign {br, bl, bb, bt, bc} = lv;

   logic [2:0] state;
   logic [8:0] p1_used, p2_used;
   logic [3:0] p1_card, p2_card;
   logic p1_locked, p2_locked, p1_black, p2_black, leader, finish, err;
   logic [3:0] round, win, lose, draw;
   logic [1:0] match_result, game_result;

   int checks = 0;
   int errors = 0;

   baw_game_ctrl #(.N_CARDS(NC), .N_ROUNDS(NR)) dut (
      .clk(clk), .reset(reset),
      .btn_center(bc), .btn_top(bt), .btn_bottom(bb), .btn_left(bl), .btn_right(br),
      .sw(sw), .state(state), .p1_used(p1_used), .p2_used(p2_used),
      .p1_card(p1_card), .p2_card(p2_card), .p1_locked(p1_locked), .p2_locked(p2_locked),
      .p1_black(p1_black), .p2_black(p2_black), .leader(leader), .round(round),
      .win(win), .lose(lose), .draw(draw), .match_result(match_result),
      .game_result(game_result), .finish(finish), .err(err)
   );

   always #5 clk = ~clk;

   // ---------------- game model ----------------
   int m_state, m_leader, m_round, m_win, m_lose, m_draw, m_mres, m_gres;
   int m_card[2];
   bit m_lock[2];
   bit m_err;
   logic [8:0] m_used[2];
   logic [4:0] m_prev;

   function automatic bit m_finish();
      return (m_win * 2 > NR) || (m_lose * 2 > NR) || (m_round == NR);
   endfunction

   task automatic m_clear();
      m_state = S_INIT; m_leader = 0; m_round = 0; m_win = 0; m_lose = 0; m_draw = 0;
      m_mres = 0; m_gres = 0; m_err = 0;
      for (int p = 0; p < 2; p++) begin m_card[p] = 0; m_lock[p] = 0; m_used[p] = '0; end
   endtask

   function automatic int inc_sat(int v);
      return (v < NR) ? v + 1 : v;
   endfunction

   task automatic model_step(input logic [4:0] l, input logic [8:0] s);
      logic [4:0] pr;
      int order[5];
      int w, p, idx;
      order = '{B, C, T, L, R};
      pr = l & ~m_prev;
      m_prev = l;
      m_err = 0;
      w = -1;
      for (int i = 0; i < 5; i++) if (w < 0 && pr[order[i]]) w = order[i];
      if (w == B) m_clear();
      else case (m_state)
         S_INIT: if (w == C) m_state = S_RASP;
         S_RASP: if (w == T) m_state = S_BAWP;
         S_BAWP: begin
            if (w == L || w == R) begin
               p = (w == R) ? 1 : 0;
               if (p != m_leader && !m_lock[m_leader]) m_err = 1;
               else m_state = p ? S_P2 : S_P1;
            end else if (w == C) begin
               if (m_lock[0] && m_lock[1]) begin
                  m_state = S_MATCH;
                  m_round = inc_sat(m_round);
                  if (m_card[0] > m_card[1]) begin m_mres = 1; m_win = inc_sat(m_win); m_leader = 0; end
                  else if (m_card[1] > m_card[0]) begin m_mres = 2; m_lose = inc_sat(m_lose); m_leader = 1; end
                  else begin m_mres = 3; m_draw = inc_sat(m_draw); end
               end else m_err = 1;
            end
         end
         S_P1, S_P2: begin
            p = (m_state == S_P2) ? 1 : 0;
            if (w == C) begin
               if ($countones(s) == 1 && (m_used[p] & s) == 0 && !m_lock[p]) begin
                  idx = 0;
                  for (int i = 0; i < NC; i++) if (s[i]) idx = i;
                  m_card[p] = idx; m_used[p] |= s; m_lock[p] = 1; m_state = S_BAWP;
               end else m_err = 1;
            end else if (w == T) m_state = S_BAWP;
         end
         S_MATCH: if (w == T) begin
            if (m_finish()) begin
               m_state = S_GAME;
               m_gres = (m_win > m_lose) ? 1 : (m_lose > m_win) ? 2 : 3;
            end else begin
               m_state = S_RASP; m_lock[0] = 0; m_lock[1] = 0; m_mres = 0;
            end
         end
         default: ;
      endcase
   endtask

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic cycle(input logic [4:0] l, input logic [8:0] s);
      lv = l; sw = s;
      @(posedge clk);
      model_step(l, s);
      @(negedge clk);
   endtask

   task automatic tap(input int b);
      logic [4:0] m;
      m = '0; m[b] = 1'b1;
      cycle(m, cur_sw);
      cycle(5'b0, cur_sw);
   endtask

   task automatic do_reset();
      reset = 1'b1; lv = '0;
      m_clear(); m_prev = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic commit(input int p, input int c);
      tap(p ? R : L);
      cur_sw = '0; cur_sw[c] = 1'b1;
      tap(C);
   endtask

   // From RASP: both players commit in turn order, then center into MATCH.
   task automatic play_round(input int c1, input int c2);
      tap(T);
      if (m_leader == 0) begin commit(0, c1); commit(1, c2); end
      else begin commit(1, c2); commit(0, c1); end
      tap(C);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
      checks++; if ({p1_used, p2_used, p1_locked, p2_locked, leader, err} !== '0) begin errors++;
         $display("FAIL reset_flags got %h want 0", {p1_used, p2_used, p1_locked, p2_locked, leader, err}); end
      checks++; if ({round, win, lose, draw, match_result, game_result, finish} !== '0) begin errors++;
         $display("FAIL reset_counters got %h want 0", {round, win, lose, draw, match_result, game_result, finish}); end
      do_reset();
   endtask

   task automatic test_first_commit();
      do_reset();
      tap(C);
      checks++; if (state !== 3'd1) begin errors++; $display("FAIL to_rasp got %0d want 1", state); end
      tap(T);
      checks++; if (state !== 3'd2) begin errors++; $display("FAIL to_bawp got %0d want 2", state); end
      tap(L);
      checks++; if (state !== 3'd3) begin errors++; $display("FAIL to_p1_turn got %0d want 3", state); end
      cur_sw = 9'h010;
      tap(C);
      checks++; if (state !== 3'd2) begin errors++; $display("FAIL commit_back got %0d want 2", state); end
      checks++; if ({p1_card, p1_locked, p1_black, p1_used} !== {4'd4, 1'b1, 1'b0, 9'h010}) begin errors++;
         $display("FAIL p1_commit got card=%0d lock=%b black=%b used=%h want 4 1 0 010", p1_card, p1_locked, p1_black, p1_used); end
   endtask

   task automatic test_match();
      do_reset();
      tap(C);
      play_round(8, 3);
      checks++; if ({state, match_result, win, round, leader} !== {3'd5, 2'b01, 4'd1, 4'd1, 1'b0}) begin errors++;
         $display("FAIL match1 got st=%0d res=%b win=%0d rnd=%0d ld=%b want 5 01 1 1 0", state, match_result, win, round, leader); end
      tap(T);
      checks++; if ({state, p1_locked, p2_locked, match_result} !== {3'd1, 4'b0}) begin errors++;
         $display("FAIL match1_exit got st=%0d locks=%b%b res=%b want 1 00 00", state, p1_locked, p2_locked, match_result); end
      play_round(2, 7);
      checks++; if ({match_result, lose, round, leader} !== {2'b10, 4'd1, 4'd2, 1'b1}) begin errors++;
         $display("FAIL match2 got res=%b lose=%0d rnd=%0d ld=%b want 10 1 2 1", match_result, lose, round, leader); end
      tap(T); tap(T);
      cycle(5'b01000, cur_sw);
      checks++; if ({state, err} !== {3'd2, 1'b1}) begin errors++;
         $display("FAIL follower_refused got st=%0d err=%b want 2 1", state, err); end
      cycle(5'b0, cur_sw);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_one_cycle got %b want 0", err); end
   endtask

   task automatic test_invalid();
      do_reset();
      tap(C); tap(T); tap(L);
      cur_sw = 9'h003;
      cycle(5'b00001, cur_sw);
      checks++; if ({state, err, p1_used, p1_locked} !== {3'd3, 1'b1, 9'h000, 1'b0}) begin errors++;
         $display("FAIL not_onehot got st=%0d err=%b used=%h lock=%b want 3 1 000 0", state, err, p1_used, p1_locked); end
      cycle(5'b0, cur_sw);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL not_onehot_pulse got %b want 0", err); end
      cur_sw = 9'h001;
      tap(C);
      tap(L);
      cur_sw = 9'h004;
      cycle(5'b00001, cur_sw);
      checks++; if ({state, err, p1_used, p1_card} !== {3'd3, 1'b1, 9'h001, 4'd0}) begin errors++;
         $display("FAIL relock got st=%0d err=%b used=%h card=%0d want 3 1 001 0", state, err, p1_used, p1_card); end
      cycle(5'b0, cur_sw);
      tap(T);
      commit(1, 1);
      tap(C);
      tap(T); tap(T); tap(R);
      cur_sw = 9'h002;
      cycle(5'b00001, cur_sw);
      checks++; if ({state, err, p2_used, p2_card} !== {3'd4, 1'b1, 9'h002, 4'd1}) begin errors++;
         $display("FAIL reused got st=%0d err=%b used=%h card=%0d want 4 1 002 1", state, err, p2_used, p2_card); end
      cycle(5'b0, cur_sw);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reused_pulse got %b want 0", err); end
   endtask

   task automatic test_finish();
      int c1[5];
      int c2[5];
      c1 = '{1, 3, 5, 7, 8};
      c2 = '{0, 2, 4, 6, 7};
      do_reset();
      tap(C);
      for (int r = 0; r < 5; r++) begin
         play_round(c1[r], c2[r]);
         if (r < 4) begin
            checks++; if (finish !== 1'b0) begin errors++; $display("FAIL early_finish round=%0d got 1 want 0", r + 1); end
            tap(T);
         end
      end
      checks++; if ({finish, win, round} !== {1'b1, 4'd5, 4'd5}) begin errors++;
         $display("FAIL finish got fin=%b win=%0d rnd=%0d want 1 5 5", finish, win, round); end
      tap(T);
      checks++; if ({state, game_result} !== {3'd6, 2'b01}) begin errors++;
         $display("FAIL game got st=%0d gres=%b want 6 01", state, game_result); end
      tap(C); tap(T); tap(L);
      checks++; if ({state, game_result} !== {3'd6, 2'b01}) begin errors++;
         $display("FAIL game_sticky got st=%0d gres=%b want 6 01", state, game_result); end
   endtask

   task automatic test_hold();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         cycle(5'b00001, cur_sw);
         if (i == 0 || i == 9) begin
            checks++; if (state !== 3'd1) begin errors++; $display("FAIL hold cyc=%0d got %0d want 1", i, state); end
         end
      end
      cycle(5'b0, cur_sw);
      tap(T);
      cycle(5'b00101, cur_sw);
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL bottom_prio got %0d want 0", state); end
      cycle(5'b0, cur_sw);
   endtask

   task automatic test_reset_mid();
      do_reset();
      tap(C);
      play_round(8, 0); tap(T);
      play_round(1, 7); tap(T);
      play_round(6, 2);
      checks++; if ({win, lose, round} !== {4'd2, 4'd1, 4'd3}) begin errors++;
         $display("FAIL score_2_1 got %0d-%0d rnd=%0d want 2-1 3", win, lose, round); end
      tap(T); tap(T);
      commit(0, 5);
      tap(R);
      checks++; if (state !== 3'd4) begin errors++; $display("FAIL mid_p2_turn got %0d want 4", state); end
      #2 reset = 1'b1;
      #1;
      checks++; if ({state, win, lose, round, p1_used, p2_used} !== '0) begin errors++;
         $display("FAIL async_reset got st=%0d w=%0d l=%0d r=%0d u=%h/%h want all 0", state, win, lose, round, p1_used, p2_used); end
      m_clear(); m_prev = '0; lv = '0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_random();
      logic [4:0] l;
      logic [8:0] s;
      int r, bad;
      do_reset();
      bad = 0;
      for (int n = 0; n < 4000; n++) begin
         r = $urandom_range(0, 199);
         if (r < 1) l = 5'b00100 | 5'($urandom_range(0, 31));
         else if (r < 80) begin
            l = '0;
            case ($urandom_range(0, 5))
               0, 1, 5: l[C] = 1'b1;
               2: l[T] = 1'b1;
               3: l[L] = 1'b1;
               default: l[R] = 1'b1;
            endcase
         end else if (r < 92) l = 5'($urandom_range(0, 31)) & 5'b11011;
         else l = '0;
         if ($urandom_range(0, 3) != 0) begin s = '0; s[$urandom_range(0, 8)] = 1'b1; end
         else s = 9'($urandom_range(0, 511));
         cycle(l, s);
         checks++; if (state !== 3'(m_state)) begin errors++; bad++;
            if (bad < 10) $display("FAIL rnd_state n=%0d got %0d want %0d", n, state, m_state); end
         checks++; if ({p1_used, p2_used} !== {m_used[0], m_used[1]}) begin errors++; bad++;
            if (bad < 10) $display("FAIL rnd_used n=%0d got %h/%h want %h/%h", n, p1_used, p2_used, m_used[0], m_used[1]); end
         checks++; if ({p1_card, p2_card, p1_black, p2_black} !== {4'(m_card[0]), 4'(m_card[1]), m_card[0][0], m_card[1][0]}) begin
            errors++; bad++;
            if (bad < 10) $display("FAIL rnd_cards n=%0d got %0d/%0d want %0d/%0d", n, p1_card, p2_card, m_card[0], m_card[1]); end
         checks++; if ({p1_locked, p2_locked, leader} !== {m_lock[0], m_lock[1], m_leader[0]}) begin errors++; bad++;
            if (bad < 10) $display("FAIL rnd_lock n=%0d got %b%b ld=%b want %b%b ld=%0d", n, p1_locked, p2_locked, leader, m_lock[0], m_lock[1], m_leader); end
         checks++; if ({round, win, lose, draw} !== {4'(m_round), 4'(m_win), 4'(m_lose), 4'(m_draw)}) begin errors++; bad++;
            if (bad < 10) $display("FAIL rnd_score n=%0d got r%0d w%0d l%0d d%0d want r%0d w%0d l%0d d%0d", n, round, win, lose, draw, m_round, m_win, m_lose, m_draw); end
         checks++; if ({match_result, game_result, finish, err} !== {2'(m_mres), 2'(m_gres), m_finish(), m_err}) begin errors++; bad++;
            if (bad < 10) $display("FAIL rnd_result n=%0d got %b %b fin=%b err=%b want %0d %0d fin=%b err=%b", n, match_result, game_result, finish, err, m_mres, m_gres, m_finish(), m_err); end
      end
   endtask

   initial begin
      m_clear(); m_prev = '0;
      test_reset();
      test_first_commit();
      test_match();
      test_invalid();
      test_finish();
      test_hold();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/baw_game_ctrl.md
# baw_game_ctrl

Parametrised game-control FSM for the Black-and-White card game on the board top level. It replaces the fixed 9-card, level-sampled controller, and sits between the synchronised buttons/switches and the display/LED renderers. It generalises card count and round count, and edge-detects buttons so one press gives exactly one transition. It enforces card validity and turn order (round winner leads next round), scores each round, and detects early game termination.

## Interface
Parameters:
- N_CARDS, 9, cards per player, valued 0..N_CARDS-1; odd value = black, even = white
- N_ROUNDS, 9, maximum rounds per game (N_ROUNDS ≤ N_CARDS)
- CW, $clog2(N_CARDS), card value width
- RW, $clog2(N_ROUNDS+1), round/score counter width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btn_center, btn_top, btn_bottom, btn_left, btn_right  in  1 each  synchronised, debounced button levels
- sw  in  N_CARDS  card-select switches
- state  out  3  current FSM state (baw_pkg encoding)
- p1_used, p2_used  out  N_CARDS  cards already played
- p1_card, p2_card  out  CW  card committed this round
- p1_locked, p2_locked  out  1  card committed this round
- p1_black, p2_black  out  1  colour of committed card (valid when locked)
- leader  out  1  0 = P1 leads this round, 1 = P2
- round  out  RW  rounds completed
- win, lose, draw  out  RW  P1-perspective tallies
- match_result, game_result  out  2  00 none, 01 P1, 10 P2, 11 draw
- finish  out  1  game decided
- err  out  1  one-cycle pulse on a rejected commit

## Operation
- Press = level & ~prev_level, per button. Only presses act. If several presses occur in one cycle, priority is bottom > center > top > left > right. Only the winning press acts.
- INIT: outputs cleared, leader=P1. center → RASP.
- RASP (round/score): top → BAWP.
- BAWP (colour display): left → P1_TURN, right → P2_TURN, center → MATCH.
  - The follower's turn is refused unless the leader is locked; state stays BAWP and err pulses.
  - center is refused with err unless both players are locked.
- P1_TURN/P2_TURN: center commits sw.
  - The commit is accepted only if sw is one-hot, the card is unused, and the player is not already locked. An accepted commit latches the card value, sets the used bit and the lock, then goes to BAWP.
  - Any rejected commit pulses err and stays in the turn state.
  - top → BAWP without commit.
- MATCH, entered via center from BAWP: result and score are updated on the entry edge.
  - Higher value wins; equal values are a draw.
  - round+1; win, lose or draw +1 as applicable.
  - leader := round winner; unchanged on a draw.
- finish = 1 when win*2 > N_ROUNDS, or lose*2 > N_ROUNDS, or round == N_ROUNDS. Computed combinationally from the registered counters.
- MATCH, top:
  - finish=1 → GAME, and game_result is latched (01 if win>lose, 10 if lose>win, 11 if equal).
  - finish=0 → RASP, locks cleared, match_result := 00.
- GAME: only bottom acts.
- bottom, from any state → INIT. All counters, used masks, cards, locks and results are cleared, and leader=P1.

## Timing
- Reset (asynchronous assert, synchronous release): state=INIT. All outputs are 0, including leader, prev_level registers and err.
- A button rising at cycle k is seen as a press at edge k+1. state, locks and scores update at that same edge, so the effect is visible 1 cycle after the level goes high.
- A button held high produces no further action until it is released for at least one cycle.
- err is high for exactly one cycle per rejected press.
- Counters saturate at N_ROUNDS and never wrap. MATCH entry is impossible once round == N_ROUNDS, because finish forces GAME.
- A reset asserted mid-round aborts immediately, with no partial score update.

## Structure
- baw_pkg holds:
  - state enum (INIT=0, RASP=1, BAWP=2, P1_TURN=3, P2_TURN=4, MATCH=5, GAME=6)
  - result encoding (RES_NONE, RES_P1, RES_P2, RES_DRAW)
  - leader constants
- Sub-module baw_btn_edge: a width-parametrised rising-edge detector with asynchronous reset, instantiated once with width 5.
- One-hot check and encode are done by a local function, not a sub-module.

## Test plan
- Reset, then center, top, left, sw=0x010, center → P1_TURN then BAWP. p1_card=4, p1_locked=1, p1_black=0, p1_used=0x010.
- P1 plays 8, P2 plays 3, then center → MATCH. match_result=01, win=1, round=1, leader=0. A next round with P2 winning sets leader=1, and left in BAWP with P2 unlocked gives err and state stays BAWP.
- Invalid commits: sw=0x003, reused card, and a second commit by a locked player → each gives one err pulse, with no change to p*_used or p*_card.
- N_ROUNDS=9: P1 wins 5 straight → finish=1 after round 5. top → GAME with game_result=01, and further center/top presses are ignored.
- btn_center held high 10 cycles in INIT → exactly one transition to RASP. Simultaneous bottom+center in BAWP → INIT.
- Reset asserted mid-P2_TURN with a score of 2-1 → same cycle: state=INIT, win=lose=round=0, masks cleared.
